text_writer: RTL and testbench

// - Upstream feeder of the screen RAM write port: turns a byte stream (CPU/UART) into

---
 rtl/text_writer.sv | 147 ++++++++++++++
 tb/tb_text_writer.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/text_writer.sv
// Byte-stream to screen-RAM character writer with an 80x25 cursor and screen/line clears.
// Define TEXT_WRITER_AUTOWRAP_EN to wrap the cursor onto a fresh line after the last column.
module text_writer #(
   parameter int          COLS      = 80,
   parameter int          ROWS      = 25,
   parameter logic [7:0]  FILL_CHAR = 8'h20
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  char_i,
   input  logic        char_valid_i,
   output logic        char_ready_o,
   output logic [11:0] ram_addr_o,
   output logic [7:0]  ram_data_o,
   output logic        ram_wren_o,
   output logic [6:0]  cursor_col_o,
   output logic [4:0]  cursor_row_o,
   output logic        busy_o
);

   typedef enum logic [1:0] {INIT_CLR, IDLE, CLR_SCREEN, CLR_LINE} state_t;

   localparam logic [6:0] COL_LAST = 7'(COLS - 1);
   localparam logic [4:0] ROW_LAST = 5'(ROWS - 1);

   state_t      state_q, state_d;
   logic [6:0]  col_q, col_d;
   logic [4:0]  row_q, row_d;
   logic [6:0]  clr_col_q, clr_col_d;
   logic [4:0]  clr_row_q, clr_row_d;
   logic [11:0] addr_q, addr_d;
   logic [7:0]  data_q, data_d;
   logic        wren_q, wren_d;
   logic        accept;
   logic [4:0]  row_inc;

   assign accept  = char_valid_i && (state_q == IDLE);
   assign row_inc = (row_q == ROW_LAST) ? 5'd0 : row_q + 5'd1;

   always_comb begin
      state_d   = state_q;
      col_d     = col_q;
      row_d     = row_q;
      clr_col_d = clr_col_q;
      clr_row_d = clr_row_q;
      addr_d    = addr_q;
      data_d    = data_q;
      wren_d    = 1'b0;
      case (state_q)
         INIT_CLR, CLR_SCREEN: begin
            addr_d = {clr_row_q, clr_col_q};
            data_d = FILL_CHAR;
            wren_d = 1'b1;
            if (clr_col_q == COL_LAST) begin
               clr_col_d = 7'd0;
               if (clr_row_q == ROW_LAST) begin
                  clr_row_d = 5'd0;
                  col_d     = 7'd0;
                  row_d     = 5'd0;
                  state_d   = IDLE;
               end else begin
                  clr_row_d = clr_row_q + 5'd1;
               end
            end else begin
               clr_col_d = clr_col_q + 7'd1;
            end
         end
         CLR_LINE: begin
            // The cursor has already moved to the row being blanked.
            addr_d = {row_q, clr_col_q};
            data_d = FILL_CHAR;
            wren_d = 1'b1;
            if (clr_col_q == COL_LAST) begin
               clr_col_d = 7'd0;
               state_d   = IDLE;
            end else begin
               clr_col_d = clr_col_q + 7'd1;
            end
         end
         IDLE: begin
            if (accept) begin
               if (char_i >= 8'h20 && char_i <= 8'h7E) begin
                  addr_d = {row_q, col_q};
                  data_d = char_i;
                  wren_d = 1'b1;
                  if (col_q != COL_LAST) begin
                     col_d = col_q + 7'd1;
                  end else begin
`ifdef TEXT_WRITER_AUTOWRAP_EN
                     col_d   = 7'd0;
                     row_d   = row_inc;
                     state_d = CLR_LINE;
`endif
                  end
               end else if (char_i == 8'h0D) begin
                  col_d = 7'd0;
               end else if (char_i == 8'h0A) begin
                  col_d   = 7'd0;
                  row_d   = row_inc;
                  state_d = CLR_LINE;
               end else if (char_i == 8'h08) begin
                  if (col_q != 7'd0) begin
                     col_d  = col_q - 7'd1;
                     addr_d = {row_q, col_q - 7'd1};
                     data_d = FILL_CHAR;
                     wren_d = 1'b1;
                  end
               end else if (char_i == 8'h0C) begin
                  state_d = CLR_SCREEN;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= INIT_CLR;
         col_q     <= 7'd0;
         row_q     <= 5'd0;
         clr_col_q <= 7'd0;
         clr_row_q <= 5'd0;
         addr_q    <= 12'd0;
         data_q    <= 8'd0;
         wren_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         col_q     <= col_d;
         row_q     <= row_d;
         clr_col_q <= clr_col_d;
         clr_row_q <= clr_row_d;
         addr_q    <= addr_d;
         data_q    <= data_d;
         wren_q    <= wren_d;
      end
   end

   assign char_ready_o = (state_q == IDLE);
   assign busy_o       = (state_q != IDLE);
   assign ram_addr_o   = addr_q;
   assign ram_data_o   = data_q;
   assign ram_wren_o   = wren_q;
   assign cursor_col_o = col_q;
   assign cursor_row_o = row_q;

endmodule

// File: tb/tb_text_writer.sv
// Directed bench for text_writer: init clear, printing, control bytes, line/screen clears, reset abort.
module tb_text_writer;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [7:0]  char_i = 8'h00;
   logic        char_valid_i = 1'b0;
   logic        char_ready_o;
   logic [11:0] ram_addr_o;
   logic [7:0]  ram_data_o;
   logic        ram_wren_o;
   logic [6:0]  cursor_col_o;
   logic [4:0]  cursor_row_o;
   logic        busy_o;

   int checks = 0;
   int errors = 0;
   logic [19:0] wq[$];

   text_writer dut (
      .clk          (clk),
      .rst          (rst),
      .char_i       (char_i),
      .char_valid_i (char_valid_i),
      .char_ready_o (char_ready_o),
      .ram_addr_o   (ram_addr_o),
      .ram_data_o   (ram_data_o),
      .ram_wren_o   (ram_wren_o),
      .cursor_col_o (cursor_col_o),
      .cursor_row_o (cursor_row_o),
      .busy_o       (busy_o)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (ram_wren_o) wq.push_back({ram_addr_o, ram_data_o});
   end

   // Counts logged writes that differ from a blank sweep (full screen if row < 0).
   function automatic int fill_errs(input int s, input int n, input int row);
      int e = 0;
      logic [11:0] a;
      for (int i = 0; i < n; i++) begin
         if (row < 0) a = {5'(i / 80), 7'(i % 80)};
         else         a = {5'(row), 7'(i)};
         if (s + i >= wq.size()) e++;
         else if (wq[s + i] !== {a, 8'h20}) e++;
      end
      return e;
   endfunction

   task automatic wait_idle(input int budget, output int n);
      n = 0;
      while (char_ready_o !== 1'b1 && n < budget) begin
         n++;
         @(negedge clk); #1;
      end
      checks++;
      if (char_ready_o !== 1'b1) begin
         errors++;
         $display("FAIL wait_idle: ready=%b after %0d cycles, required 1", char_ready_o, n);
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      char_i = b;
      char_valid_i = 1'b1;
      @(posedge clk);
      @(negedge clk); #1;
      char_valid_i = 1'b0;
      char_i = 8'h00;
   endtask

   task automatic check_cursor(input string name, input int row, input int col);
      checks++;
      if (cursor_row_o !== 5'(row) || cursor_col_o !== 7'(col)) begin
         errors++;
         $display("FAIL %s: cursor=(%0d,%0d) required (%0d,%0d)", name, cursor_row_o, cursor_col_o, row, col);
      end
   endtask

   task automatic test_reset();
      int n;
      @(negedge clk); #1;
      checks++;
      if (ram_wren_o !== 1'b0 || ram_addr_o !== 12'h000 || ram_data_o !== 8'h00) begin
         errors++;
         $display("FAIL reset_ram: wren=%b addr=%h data=%h required 0/000/00", ram_wren_o, ram_addr_o, ram_data_o);
      end
      check_cursor("reset_cursor", 0, 0);
      checks++;
      if (char_ready_o !== 1'b0 || busy_o !== 1'b1) begin
         errors++;
         $display("FAIL reset_state: ready=%b busy=%b required 0/1", char_ready_o, busy_o);
      end
      wq.delete();
      rst = 1'b0;
      wait_idle(2100, n);
      checks++;
      if (wq.size() != 2000) begin
         errors++;
         $display("FAIL init_count: writes=%0d required 2000", wq.size());
      end
      checks++;
      if (fill_errs(0, 2000, -1) != 0) begin
         errors++;
         $display("FAIL init_fill: bad writes=%0d required 0", fill_errs(0, 2000, -1));
      end
      check_cursor("init_cursor", 0, 0);
   endtask

   task automatic test_print_ab();
      wq.delete();
      send_byte(8'h41);
      checks++;
      if (wq.size() != 1 || wq[0] !== {12'h000, 8'h41}) begin
         errors++;
         $display("FAIL print_a: writes=%0d first=%h required 1 write of 00041", wq.size(), (wq.size() > 0) ? wq[0] : 20'h0);
      end
      check_cursor("print_a_cursor", 0, 1);
      send_byte(8'h42);
      checks++;
      if (wq.size() != 2 || wq[1] !== {12'h001, 8'h42}) begin
         errors++;
         $display("FAIL print_b: writes=%0d second=%h required 00142", wq.size(), (wq.size() > 1) ? wq[1] : 20'h0);
      end
      check_cursor("print_b_cursor", 0, 2);
      @(negedge clk); #1;
      checks++;
      if (ram_wren_o !== 1'b0) begin
         errors++;
         $display("FAIL print_wren_pulse: wren=%b required 0", ram_wren_o);
      end
   endtask

   task automatic test_cr_other();
      wq.delete();
      send_byte(8'h0D);
      check_cursor("cr_cursor", 0, 0);
      send_byte(8'h41);
      send_byte(8'h01);
      checks++;
      if (wq.size() != 1) begin
         errors++;
         $display("FAIL cr_other_writes: writes=%0d required 1", wq.size());
      end
      check_cursor("other_cursor", 0, 1);
      send_byte(8'h0D);
   endtask

   task automatic test_lf();
      int n;
      for (int r = 0; r < 3; r++) begin
         send_byte(8'h0A);
         wait_idle(200, n);
      end
      for (int c = 0; c < 10; c++) send_byte(8'h61);
      check_cursor("lf_pre_cursor", 3, 10);
      wq.delete();
      send_byte(8'h0A);
      check_cursor("lf_cursor", 4, 0);
      checks++;
      if (wq.size() != 0) begin
         errors++;
         $display("FAIL lf_no_write: writes=%0d required 0", wq.size());
      end
      wait_idle(200, n);
      checks++;
      if (n != 80) begin
         errors++;
         $display("FAIL lf_busy_len: ready low %0d cycles required 80", n);
      end
      checks++;
      if (wq.size() != 80 || fill_errs(0, 80, 4) != 0) begin
         errors++;
         $display("FAIL lf_clear: writes=%0d bad=%0d required 80/0", wq.size(), fill_errs(0, 80, 4));
      end
   endtask

   task automatic test_bs();
      wq.delete();
      send_byte(8'h08);
      checks++;
      if (wq.size() != 0) begin
         errors++;
         $display("FAIL bs_col0: writes=%0d required 0", wq.size());
      end
      check_cursor("bs_col0_cursor", 4, 0);
      for (int c = 0; c < 5; c++) send_byte(8'h78);
      wq.delete();
      send_byte(8'h08);
      checks++;
      if (wq.size() != 1 || wq[0] !== {12'h204, 8'h20}) begin
         errors++;
         $display("FAIL bs_col5: writes=%0d first=%h required 20420", wq.size(), (wq.size() > 0) ? wq[0] : 20'h0);
      end
      check_cursor("bs_col5_cursor", 4, 4);
   endtask

   task automatic test_wrap();
      int n;
      send_byte(8'h0D);
      for (int r = 0; r < 20; r++) begin
         send_byte(8'h0A);
         wait_idle(200, n);
      end
      for (int c = 0; c < 79; c++) send_byte(8'h77);
      check_cursor("wrap_pre_cursor", 24, 79);
      wq.delete();
      send_byte(8'h5A);
      checks++;
      if (wq.size() != 1 || wq[0] !== {12'hC4F, 8'h5A}) begin
         errors++;
         $display("FAIL wrap_write: writes=%0d first=%h required C4F5A", wq.size(), (wq.size() > 0) ? wq[0] : 20'h0);
      end
`ifdef TEXT_WRITER_AUTOWRAP_EN
      check_cursor("wrap_cursor", 0, 0);
      wait_idle(200, n);
      checks++;
      if (wq.size() != 81 || fill_errs(1, 80, 0) != 0) begin
         errors++;
         $display("FAIL wrap_clear: writes=%0d bad=%0d required 81/0", wq.size(), fill_errs(1, 80, 0));
      end
`else
      check_cursor("nowrap_cursor", 24, 79);
      checks++;
      if (char_ready_o !== 1'b1) begin
         errors++;
         $display("FAIL nowrap_ready: ready=%b required 1", char_ready_o);
      end
      send_byte(8'h59);
      checks++;
      if (wq.size() != 2 || wq[1] !== {12'hC4F, 8'h59}) begin
         errors++;
         $display("FAIL nowrap_overwrite: writes=%0d second=%h required C4F59", wq.size(), (wq.size() > 1) ? wq[1] : 20'h0);
      end
      check_cursor("nowrap_cursor2", 24, 79);
`endif
   endtask

   task automatic test_ff();
      int n;
      send_byte(8'h0D);
      send_byte(8'h41);
      wq.delete();
      send_byte(8'h0C);
      checks++;
      if (busy_o !== 1'b1 || char_ready_o !== 1'b0) begin
         errors++;
         $display("FAIL ff_busy: busy=%b ready=%b required 1/0", busy_o, char_ready_o);
      end
      wait_idle(2100, n);
      checks++;
      if (wq.size() != 2000 || fill_errs(0, 2000, -1) != 0) begin
         errors++;
         $display("FAIL ff_clear: writes=%0d bad=%0d required 2000/0", wq.size(), fill_errs(0, 2000, -1));
      end
      check_cursor("ff_cursor", 0, 0);
   endtask

   task automatic test_ff_reset();
      int n;
      int k;
      send_byte(8'h41);
      wq.delete();
      send_byte(8'h0C);
      k = 0;
      while (wq.size() < 1000 && k < 1100) begin
         k++;
         @(negedge clk); #1;
      end
      rst = 1'b1;
      #1;
      checks++;
      if (ram_wren_o !== 1'b0 || ram_addr_o !== 12'h000 || ram_data_o !== 8'h00 || char_ready_o !== 1'b0) begin
         errors++;
         $display("FAIL abort_outputs: wren=%b addr=%h data=%h ready=%b required 0/000/00/0", ram_wren_o, ram_addr_o, ram_data_o, char_ready_o);
      end
      check_cursor("abort_cursor", 0, 0);
      @(negedge clk); #1;
      wq.delete();
      rst = 1'b0;
      wait_idle(2100, n);
      checks++;
      if (wq.size() != 2000 || fill_errs(0, 2000, -1) != 0) begin
         errors++;
         $display("FAIL restart_clear: writes=%0d bad=%0d required 2000/0", wq.size(), fill_errs(0, 2000, -1));
      end
   endtask

   initial begin
      test_reset();
      test_print_ab();
      test_cr_other();
      test_lf();
      test_bs();
      test_wrap();
      test_ff();
      test_ff_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
